// File: rtl/code_pulse_decoder_if.sv
// Handshake and strobe bundle for code_pulse_decoder.
// The slave modport is the decoder side; the master modport is the code source and strobe sink.
interface code_pulse_decoder_if #(
  parameter int DEPTH = 4
) ();
  localparam int LW = $clog2(DEPTH) + 1;

  logic [1:0]    code_in;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    code_out;
  logic          out_valid;
  logic [LW-1:0] level;
  logic          busy;

  modport master (
    output code_in, in_valid,
    input  in_ready, code_out, out_valid, level, busy
  );

  modport slave (
    input  code_in, in_valid,
    output in_ready, code_out, out_valid, level, busy
  );
endinterface

// File: rtl/code_pulse_decoder.sv
// Buffers 2-bit codes in a small FIFO and replays each one as a timed one-hot strobe.
// Every strobe is followed by a fixed all-zero gap.
module code_pulse_decoder #(
  parameter int DEPTH     = 4,
  parameter int PULSE_LEN = 3,
  parameter int GAP_LEN   = 1
) (
  input logic               clk,
  input logic               rst_n,
  code_pulse_decoder_if.slave bus
);
  localparam int PW   = $clog2(DEPTH);
  localparam int LW   = PW + 1;
  localparam int CMAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t        r_state;
  logic [1:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_code;
  logic          r_out_valid;
  logic          r_in_ready;
  logic          r_busy;

  state_t        w_next_state;
  logic [CW-1:0] w_next_cnt;
  logic [3:0]    w_next_code;
  logic [LW-1:0] w_next_level;
  logic [3:0]    w_strobe;
  logic          w_push;
  logic          w_pop;

  // Full-refusal uses only the registered ready, so a same-edge pop never frees a slot early.
  assign w_push       = bus.in_valid && r_in_ready;
  assign w_strobe     = 4'b0001 << r_mem[r_rd_ptr];
  assign w_next_level = r_level + LW'(w_push) - LW'(w_pop);

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_code  = r_code;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_level != '0) begin
          w_pop        = 1'b1;
          w_next_code  = w_strobe;
          w_next_cnt   = CW'(PULSE_LEN - 1);
          w_next_state = S_PULSE;
        end
      end
      S_PULSE: begin
        if (r_cnt != '0) begin
          w_next_cnt = r_cnt - 1'b1;
        end else begin
          w_next_code  = 4'b0000;
          w_next_cnt   = CW'(GAP_LEN - 1);
          w_next_state = S_GAP;
        end
      end
      S_GAP: begin
        if (r_cnt != '0) begin
          w_next_cnt = r_cnt - 1'b1;
        end else if (r_level != '0) begin
          w_pop        = 1'b1;
          w_next_code  = w_strobe;
          w_next_cnt   = CW'(PULSE_LEN - 1);
          w_next_state = S_PULSE;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_code  = 4'b0000;
        w_next_cnt   = '0;
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_cnt       <= '0;
      r_code      <= 4'b0000;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_cnt       <= w_next_cnt;
      r_code      <= w_next_code;
      r_out_valid <= (w_next_code != 4'b0000);
      r_level     <= w_next_level;
      r_in_ready  <= (w_next_level != LW'(DEPTH));
      r_busy      <= (w_next_state != S_IDLE) || (w_next_level != '0);
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Storage needs no reset: entries are only read when level says they hold valid data.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.code_in;
    end
  end

  assign bus.code_out  = r_code;
  assign bus.out_valid = r_out_valid;
  assign bus.in_ready  = r_in_ready;
  assign bus.level     = r_level;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_code_pulse_decoder.sv
// Directed bench for code_pulse_decoder at DEPTH=4, PULSE_LEN=3, GAP_LEN=1.
// Inputs change and outputs are sampled on the falling edge, away from the active edge.
module tb_code_pulse_decoder;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk;
  logic rst_n;
  int   testCount;
  int   failCount;

  code_pulse_decoder_if #(.DEPTH(DEPTH)) bus ();

  code_pulse_decoder #(
    .DEPTH    (DEPTH),
    .PULSE_LEN(3),
    .GAP_LEN  (1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Back-to-back stream: pushes 0,1,2,3 on the first four edges.
  logic [3:0]    b2bCode  [18] = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010,
                                   4'b0010, 4'b0010, 4'b0000, 4'b0100, 4'b0100, 4'b0100,
                                   4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000};
  logic [LW-1:0] b2bLevel [18] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd3, 3'd2, 3'd2, 3'd2, 3'd2,
                                   3'd1, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};

  // Full/wrap run: in_valid held for 10 edges with codes 3,2,1,0,3,2,1,0,3,2; only 3,2,1,0,3,1 get in.
  logic [1:0]    fullIn    [10] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2};
  logic [3:0]    fullCode  [26] = '{4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0100,
                                    4'b0100, 4'b0100, 4'b0000, 4'b0010, 4'b0010, 4'b0010,
                                    4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b1000,
                                    4'b1000, 4'b1000, 4'b0000, 4'b0010, 4'b0010, 4'b0010,
                                    4'b0000, 4'b0000};
  logic [LW-1:0] fullLevel [26] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd3, 3'd4, 3'd4, 3'd4,
                                    3'd3, 3'd3, 3'd3, 3'd3, 3'd2, 3'd2, 3'd2, 3'd2, 3'd1,
                                    3'd1, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
  logic          fullReady [26] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                                    1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                    1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  // Drives one cycle of input from the current falling edge through the next one.
  task automatic applyStimulus(input logic valid, input logic [1:0] code);
    bus.in_valid = valid;
    bus.code_in  = code;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] expCode, input logic expValid,
                             input logic expReady, input logic [LW-1:0] expLevel,
                             input logic expBusy);
    logic [LW+6:0] observed;
    logic [LW+6:0] expected;
    observed = {bus.code_out, bus.out_valid, bus.in_ready, bus.level, bus.busy};
    expected = {expCode, expValid, expReady, expLevel, expBusy};
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed code=%b valid=%b ready=%b level=%0d busy=%b, expected code=%b valid=%b ready=%b level=%0d busy=%b",
             tag, bus.code_out, bus.out_valid, bus.in_ready, bus.level, bus.busy,
             expCode, expValid, expReady, expLevel, expBusy);
    end
  endtask

  initial begin
    testCount    = 0;
    failCount    = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.code_in  = 2'd0;

    @(negedge clk);
    checkOutput("reset_hold", 4'b0000, 1'b0, 1'b1, 3'd0, 1'b0);
    applyStimulus(1'b1, 2'd3);
    checkOutput("reset_ignores_valid", 4'b0000, 1'b0, 1'b1, 3'd0, 1'b0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 2'd0);
    checkOutput("reset_release", 4'b0000, 1'b0, 1'b1, 3'd0, 1'b0);

    applyStimulus(1'b1, 2'd2);
    checkOutput("single_push", 4'b0000, 1'b0, 1'b1, 3'd1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 2'd0);
      checkOutput($sformatf("single_pulse%0d", i), 4'b0100, 1'b1, 1'b1, 3'd0, 1'b1);
    end
    applyStimulus(1'b0, 2'd0);
    checkOutput("single_gap", 4'b0000, 1'b0, 1'b1, 3'd0, 1'b1);
    applyStimulus(1'b0, 2'd0);
    checkOutput("single_idle", 4'b0000, 1'b0, 1'b1, 3'd0, 1'b0);

    for (int i = 0; i < 18; i++) begin
      logic [1:0] c;
      c = 2'(i);
      applyStimulus(i < 4, c);
      checkOutput($sformatf("b2b_e%0d", i), b2bCode[i], b2bCode[i] != 4'b0000, 1'b1,
                  b2bLevel[i], i != 17);
    end

    for (int i = 0; i < 26; i++) begin
      applyStimulus(i < 10, (i < 10) ? fullIn[i] : 2'd0);
      checkOutput($sformatf("full_e%0d", i), fullCode[i], fullCode[i] != 4'b0000,
                  fullReady[i], fullLevel[i], i != 25);
    end

    applyStimulus(1'b1, 2'd3);
    checkOutput("prereset_push3", 4'b0000, 1'b0, 1'b1, 3'd1, 1'b1);
    applyStimulus(1'b1, 2'd1);
    checkOutput("prereset_pulse", 4'b1000, 1'b1, 1'b1, 3'd1, 1'b1);
    applyStimulus(1'b1, 2'd2);
    checkOutput("prereset_level2", 4'b1000, 1'b1, 1'b1, 3'd2, 1'b1);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 checkOutput("midpulse_reset_async", 4'b0000, 1'b0, 1'b1, 3'd0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 2'd0);
    checkOutput("midpulse_reset_held", 4'b0000, 1'b0, 1'b1, 3'd0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 2'd0);
      checkOutput($sformatf("no_stale_%0d", i), 4'b0000, 1'b0, 1'b1, 3'd0, 1'b0);
    end
    applyStimulus(1'b1, 2'd1);
    checkOutput("post_reset_push", 4'b0000, 1'b0, 1'b1, 3'd1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 2'd0);
      checkOutput($sformatf("post_reset_pulse%0d", i), 4'b0010, 1'b1, 1'b1, 3'd0, 1'b1);
    end
    applyStimulus(1'b0, 2'd0);
    checkOutput("post_reset_gap", 4'b0000, 1'b0, 1'b1, 3'd0, 1'b1);
    applyStimulus(1'b0, 2'd0);
    checkOutput("post_reset_idle", 4'b0000, 1'b0, 1'b1, 3'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule
